median_filter_scalable: RTL and testbench

MEDIAN_FILTER_SCALABLE -- requirements
Module: median_filter_scalable

---
 rtl/median_filter_scalable.sv | 74 +++++++
 tb/tb_median_filter_scalable.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/median_filter_scalable.sv
// median_filter_scalable: 3x3 median filter over a streamed row window, one output row per clock
module median_filter_scalable #(
  parameter int SIZE  = 100,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] arr_in  [SIZE-1:0],
  output logic [WIDTH-1:0] arr_out [SIZE-3:0],
  output logic             out_valid
);

  // Compare-exchange pairs of the 19-stage 9-input median network; the median ends in slot 4.
  // Each pair orders (lo, hi) so that slot lo receives the smaller value.
  localparam int LO [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int HI [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

  logic [WIDTH-1:0] row_a_q [SIZE-1:0];
  logic [WIDTH-1:0] row_b_q [SIZE-1:0];
  logic [WIDTH-1:0] row_c_q [SIZE-1:0];
  logic [1:0]       fill_q;
  logic [1:0]       fill_d;

  function automatic logic [WIDTH-1:0] med9(input logic [WIDTH-1:0] v [9]);
    logic [WIDTH-1:0] p [9];
    logic [WIDTH-1:0] t;
    p = v;
    for (int i = 0; i < 19; i++) begin
      if (p[LO[i]] > p[HI[i]]) begin
        t         = p[LO[i]];
        p[LO[i]]  = p[HI[i]];
        p[HI[i]]  = t;
      end
    end
    return p[4];
  endfunction

  // Fill counter saturates at 3 so out_valid stays high for the rest of the stream
  always_comb fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;

  // Row window shifts every cycle; reset discards any partial window immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        row_a_q[i] <= '0;
        row_b_q[i] <= '0;
        row_c_q[i] <= '0;
      end
      fill_q <= 2'd0;
    end else begin
      row_a_q <= row_b_q;
      row_b_q <= row_c_q;
      row_c_q <= arr_in;
      fill_q  <= fill_d;
    end
  end

  assign out_valid = (fill_q == 2'd3);

  for (genvar k = 0; k < SIZE - 2; k++) begin : g_col
    logic [WIDTH-1:0] win [9];
    assign win[0] = row_a_q[k];
    assign win[1] = row_a_q[k+1];
    assign win[2] = row_a_q[k+2];
    assign win[3] = row_b_q[k];
    assign win[4] = row_b_q[k+1];
    assign win[5] = row_b_q[k+2];
    assign win[6] = row_c_q[k];
    assign win[7] = row_c_q[k+1];
    assign win[8] = row_c_q[k+2];
    assign arr_out[k] = med9(win);
  end

endmodule

// File: tb/tb_median_filter_scalable.sv
// tb_median_filter_scalable: directed and randomized checks of the 3x3 median filter at SIZE=5 and SIZE=100
module tb_median_filter_scalable;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in5    [4:0];
  logic [7:0] out5   [2:0];
  logic       v5;
  logic [7:0] in100  [99:0];
  logic [7:0] out100 [97:0];
  logic       v100;

  int errors = 0;
  int checks = 0;
  int hist [0:63][5];
  int n5 = 0;
  int img [100][100];

  median_filter_scalable #(.SIZE(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .arr_in(in5), .arr_out(out5), .out_valid(v5)
  );

  median_filter_scalable #(.SIZE(100), .WIDTH(8)) dut100 (
    .clk(clk), .rst(rst), .arr_in(in100), .arr_out(out100), .out_valid(v100)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Median as the 5th smallest of nine values, found by sorting
  function automatic int med(input int v [9]);
    int s [9];
    int t;
    s = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  // Expected SIZE=5 output from the last three rows loaded since reset (missing rows read as 0)
  task automatic check5(input string tag);
    int w [3][5];
    int v [9];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        w[r][c] = (n5 - 3 + r >= 0) ? hist[n5-3+r][c] : 0;
    chk({tag, "_valid"}, int'(v5), int'(n5 >= 3));
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 3; r++)
        for (int d = 0; d < 3; d++)
          v[r*3+d] = w[r][k+d];
      chk($sformatf("%s_col%0d", tag, k), int'(out5[k]), med(v));
    end
  endtask

  task automatic load5(input string tag, input int r [5]);
    for (int c = 0; c < 5; c++) in5[c] = 8'(r[c]);
    tick();
    for (int c = 0; c < 5; c++) hist[n5][c] = r[c];
    n5++;
    check5(tag);
  endtask

  initial begin
    int r [5];
    int v [9];
    int vcnt;
    int bc;
    int be;
    int e;
    for (int c = 0; c < 5; c++) in5[c] = 8'd0;
    for (int c = 0; c < 100; c++) in100[c] = 8'd0;

    // Reset state
    tick();
    tick();
    chk("rst_v5", int'(v5), 0);
    chk("rst_v100", int'(v100), 0);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_out5_%0d", k), int'(out5[k]), 0);
    chk("rst_out100_0", int'(out100[0]), 0);
    chk("rst_out100_97", int'(out100[97]), 0);
    rst = 1'b0;
    n5 = 0;
    chk("edge0_valid", int'(v5), 0);

    // Ramp rows: first valid output after the third load
    r = '{1, 2, 3, 4, 5};      load5("ramp1", r);
    r = '{6, 7, 8, 9, 10};     load5("ramp2", r);
    r = '{11, 12, 13, 14, 15}; load5("ramp3", r);
    chk("ramp_out0", int'(out5[0]), 7);
    chk("ramp_out1", int'(out5[1]), 8);
    chk("ramp_out2", int'(out5[2]), 9);
    r = '{16, 17, 18, 19, 20}; load5("ramp4", r);
    chk("edge4_valid", int'(v5), 1);

    // Single impulse is removed
    r = '{0, 0, 0, 0, 0};   load5("imp1", r);
    r = '{0, 255, 0, 0, 0}; load5("imp2", r);
    r = '{0, 0, 0, 0, 0};   load5("imp3", r);
    for (int k = 0; k < 3; k++) chk($sformatf("imp_out%0d", k), int'(out5[k]), 0);

    // Single dark pixel in a flat field is removed
    r = '{200, 200, 200, 200, 200}; load5("flat1", r);
    r = '{200, 200, 0, 200, 200};   load5("flat2", r);
    r = '{200, 200, 200, 200, 200}; load5("flat3", r);
    for (int k = 0; k < 3; k++) chk($sformatf("flat_out%0d", k), int'(out5[k]), 200);

    // Mid-stream asynchronous reset after two loads
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n5 = 0;
    r = '{200, 200, 200, 200, 200}; load5("part1", r);
    r = '{200, 200, 200, 200, 200}; load5("part2", r);
    chk("part_nonzero", int'(out5[1]), 200);
    #3;
    rst = 1'b1;
    #1;
    n5 = 0;
    chk("async_v5", int'(v5), 0);
    for (int k = 0; k < 3; k++) chk($sformatf("async_out%0d", k), int'(out5[k]), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 5; c++) r[c] = int'($urandom_range(0, 255));
      load5($sformatf("refill%0d", i), r);
    end

    // Randomized rows against the window model
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 5; c++) r[c] = int'($urandom_range(0, 255));
      load5($sformatf("rand%0d", i), r);
    end

    // SIZE=100 image stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int y = 0; y < 100; y++)
      for (int x = 0; x < 100; x++)
        img[y][x] = int'($urandom_range(0, 255));
    vcnt = 0;
    for (int n = 0; n < 100; n++) begin
      for (int c = 0; c < 100; c++) in100[c] = 8'(img[n][c]);
      tick();
      if (v100) vcnt++;
      chk($sformatf("img_valid%0d", n), int'(v100), int'(n >= 2));
      if (n >= 2) begin
        bc = -1;
        be = 0;
        for (int k = 0; k < 98; k++) begin
          for (int r2 = 0; r2 < 3; r2++)
            for (int d = 0; d < 3; d++)
              v[r2*3+d] = img[n-2+r2][k+d];
          e = med(v);
          if (k == 0) be = e;
          if (bc < 0 && int'(out100[k]) != e) begin
            bc = k;
            be = e;
          end
        end
        if (bc < 0) bc = 0;
        chk($sformatf("img_row%0d_col%0d", n - 1, bc + 1), int'(out100[bc]), be);
      end
    end
    chk("img_valid_rows", vcnt, 98);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
